// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: MEM-stage request/response signals and RAM port of dmem_ctrl
interface dmem_ctrl_if;
    logic        dmemREN, dmemWEN, dhit, derr, ramREN, ramWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        output dhit, dmemload, derr, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        input  dhit, dmemload, derr, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage load/store responder with timeout watchdog; DMEM_LOADBUF_EN adds a one-entry load buffer
module dmem_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int WORD_W  = 32
) (
    input logic        CLK,
    input logic        nRST,
    dmem_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ACCESS = 2'b10, RAM_ERR = 2'b11;
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    state_t        state, next;
    logic [CW-1:0] cnt, cnt_n;
    logic          wr, wr_n, req, hit;
`ifdef DMEM_LOADBUF_EN
    logic          buf_valid;
    logic [29:0]   buf_addr;
    logic [31:0]   buf_data;
    assign hit = buf_valid && buf_addr == bus.dmemaddr[31:2];
`else
    assign hit = 1'b0;
`endif
    always_comb begin
        req   = bus.dmemREN | bus.dmemWEN;
        next  = state;
        cnt_n = cnt;
        wr_n  = wr;
        case (state)
            IDLE: if (req) begin
                wr_n  = bus.dmemWEN;
                cnt_n = '0;
                next  = bus.dmemaddr[1:0] != 2'b00 ? ERR : (!bus.dmemWEN && hit) ? RESP : REQ;
            end
            REQ: begin
                if (bus.ramstate == ACCESS) next = RESP;
                else if (bus.ramstate == RAM_ERR || cnt == CW'(TIMEOUT - 1)) next = ERR;
                else cnt_n = cnt + 1'b1;
            end
            RESP: next = IDLE;
            default: next = ERR;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= IDLE;
            cnt          <= '0;
            wr           <= 1'b0;
            bus.dhit     <= 1'b0;
            bus.derr     <= 1'b0;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.dmemload <= '0;
            bus.ramaddr  <= '0;
            bus.ramstore <= '0;
`ifdef DMEM_LOADBUF_EN
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
`endif
        end else begin
            state      <= next;
            cnt        <= cnt_n;
            wr         <= wr_n;
            bus.dhit   <= next == RESP;
            bus.derr   <= next == ERR;
            bus.ramREN <= next == REQ && !wr_n;
            bus.ramWEN <= next == REQ && wr_n;
            if (state == IDLE && next == REQ) begin
                bus.ramaddr <= bus.dmemaddr[WORD_W-1:0];
                if (wr_n) bus.ramstore <= bus.dmemstore[WORD_W-1:0];
            end
            if (state == REQ && next == RESP && !wr) bus.dmemload <= bus.ramload;
`ifdef DMEM_LOADBUF_EN
            if (state == IDLE && next == RESP) bus.dmemload <= buf_data;
            if (state == REQ && next == RESP && !wr) begin
                buf_valid <= 1'b1;
                buf_addr  <= bus.ramaddr[31:2];
                buf_data  <= bus.ramload;
            end
            if ((state == IDLE && next == REQ && wr_n) || next == ERR) buf_valid <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized transaction-level check of dmem_ctrl against a timeline model
module tb_dmem_ctrl;
    localparam int TO = 4;
`ifdef DMEM_LOADBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif
    logic CLK = 1'b0, nRST = 1'b0;
    dmem_ctrl_if bus();
    dmem_ctrl #(.TIMEOUT(TO), .WORD_W(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    always #5 CLK = ~CLK;
    int checks = 0, errors = 0;
    bit active = 0;
    logic exp_dhit, exp_derr, exp_ren, exp_wen, chk_addr, chk_store;
    logic [31:0] exp_load, exp_addr, exp_store;
    bit bvalid;
    logic [29:0] baddr;
    logic [31:0] bdata;
    int cyc = 0, req_cyc = 0, dhit_at = 0, ren_cnt = 0, wen_cnt = 0, dhit_cnt = 0;
    logic [31:0] last_addr, last_store;
    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endfunction
    always @(negedge CLK) if (active) begin
        cyc++;
        chk("dhit", 32'(bus.dhit), 32'(exp_dhit));
        chk("derr", 32'(bus.derr), 32'(exp_derr));
        chk("ramREN", 32'(bus.ramREN), 32'(exp_ren));
        chk("ramWEN", 32'(bus.ramWEN), 32'(exp_wen));
        chk("dmemload", bus.dmemload, exp_load);
        if (chk_addr) chk("ramaddr", bus.ramaddr, exp_addr);
        if (chk_store) chk("ramstore", bus.ramstore, exp_store);
        if (bus.ramREN === 1'b1) begin ren_cnt++; last_addr = bus.ramaddr; end
        if (bus.ramWEN === 1'b1) begin wen_cnt++; last_addr = bus.ramaddr; last_store = bus.ramstore; end
        if (bus.dhit === 1'b1) begin dhit_cnt++; dhit_at = cyc; end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic drop();
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask
    task automatic clr();
        ren_cnt = 0; wen_cnt = 0; dhit_cnt = 0; dhit_at = 0;
    endtask
    task automatic reset_exp();
        exp_dhit = 0; exp_derr = 0; exp_ren = 0; exp_wen = 0;
        exp_load = '0; exp_addr = '0; exp_store = '0;
        chk_addr = 1; chk_store = 1; bvalid = 0; active = 1;
    endtask
    task automatic do_reset();
        nRST = 1'b0;
        drop();
        tick();
        reset_exp();
        nRST = 1'b1;
    endtask
    task automatic go_err();
        exp_derr = 1; exp_ren = 0; exp_wen = 0; bvalid = 0;
        drop();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drop();
            bus.ramstate = 2'($urandom);
            bus.ramload = $urandom;
            tick();
        end
    endtask
    task automatic err_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dmemREN = 1'($urandom); bus.dmemWEN = 1'($urandom);
            bus.dmemaddr = $urandom & 32'hFFFF_FFFC; bus.dmemstore = $urandom;
            bus.ramstate = 2'($urandom); bus.ramload = $urandom;
            tick();
        end
        drop();
    endtask
    // One transaction: nwait non-ACCESS cycles, then ACCESS (or ERROR); rst_at pulls reset in that REQ cycle
    task automatic txn(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int nwait, input bit term_err, input int rst_at);
        bit rd, hit;
        rd = !wen;
        hit = LB && rd && bvalid && baddr == addr[31:2];
        bus.dmemREN = ren; bus.dmemWEN = wen; bus.dmemaddr = addr; bus.dmemstore = data;
        bus.ramstate = 2'($urandom); bus.ramload = $urandom;
        req_cyc = cyc + 1;
        tick();
        if (addr[1:0] != 2'b00) begin go_err(); return; end
        if (hit) begin
            exp_dhit = 1; exp_load = bdata;
            drop(); tick(); exp_dhit = 0;
            return;
        end
        if (wen) bvalid = 0;
        for (int j = 1; ; j++) begin
            exp_ren = rd; exp_wen = wen; chk_addr = 1; exp_addr = addr; chk_store = wen; exp_store = data;
            bus.dmemREN = 1'($urandom); bus.dmemWEN = 1'($urandom);
            bus.dmemaddr = $urandom; bus.dmemstore = $urandom;
            bus.ramstate = j <= nwait ? 2'($urandom_range(0, 1)) : (term_err ? 2'b11 : 2'b10);
            bus.ramload = j == nwait + 1 ? rdata : $urandom;
            if (j == rst_at) begin
                nRST = 1'b0; tick(); reset_exp(); nRST = 1'b1; drop();
                return;
            end
            tick();
            chk_addr = 0; chk_store = 0; exp_ren = 0; exp_wen = 0;
            if (j <= nwait) begin
                if (j == TO) begin go_err(); return; end
            end else if (term_err) begin
                go_err(); return;
            end else begin
                exp_dhit = 1;
                if (rd) begin exp_load = rdata; bvalid = 1; baddr = addr[31:2]; bdata = rdata; end
                drop(); tick(); exp_dhit = 0;
                return;
            end
        end
    endtask
    initial begin
        drop();
        bus.dmemaddr = '0; bus.dmemstore = '0; bus.ramstate = 2'b00; bus.ramload = '0;
        do_reset();
        idle(2);
        clr(); txn(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0, 0); idle(1);
        chk("rd_ren_cycles", ren_cnt, 1);
        chk("rd_addr", last_addr, 32'h40);
        chk("rd_latency", dhit_at - req_cyc, 2);
        chk("rd_dhit_count", dhit_cnt, 1);
        chk("rd_load", bus.dmemload, 32'hDEADBEEF);
        clr(); txn(0, 1, 32'h100, 32'h12345678, 32'h0, 3, 0, 0); idle(1);
        chk("wr_wen_cycles", wen_cnt, 4);
        chk("wr_store", last_store, 32'h12345678);
        chk("wr_latency", dhit_at - req_cyc, 5);
        chk("wr_load_kept", bus.dmemload, 32'hDEADBEEF);
        clr(); txn(1, 1, 32'h8, 32'hA5A5A5A5, $urandom, 0, 0, 0); idle(1);
        chk("both_ren", ren_cnt, 0);
        chk("both_wen", wen_cnt, 1);
        chk("both_dhit", dhit_cnt, 1);
        clr(); txn(1, 0, 32'h200, 32'h0, 32'h0, 50, 0, 0); err_idle(20);
        chk("to_req_cycles", ren_cnt, TO);
        chk("to_dhit", dhit_cnt, 0);
        chk("to_derr", 32'(bus.derr), 1);
        do_reset();
        chk("to_derr_cleared", 32'(bus.derr), 0);
        clr(); txn(1, 0, 32'h42, 32'h0, 32'h0, 0, 0, 0);
        chk("mis_derr", 32'(bus.derr), 1);
        err_idle(3);
        chk("mis_ren", ren_cnt, 0);
        do_reset();
        idle(1);
        txn(1, 0, 32'h40, 32'h0, 32'h11111111, 5, 0, 2);
        chk("mid_rst_ren", 32'(bus.ramREN), 0);
        chk("mid_rst_load", bus.dmemload, 0);
        idle(1);
        txn(1, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0, 0); idle(1);
        chk("post_rst_load", bus.dmemload, 32'hCAFEF00D);
        clr(); txn(1, 0, 32'h40, 32'h0, 32'h0BADF00D, 0, 0, 0); idle(1);
        chk("repeat_ren", ren_cnt, LB ? 0 : 1);
        chk("repeat_load", bus.dmemload, LB ? 32'hCAFEF00D : 32'h0BADF00D);
        txn(0, 1, 32'h40, 32'h55AA55AA, 32'h0, 0, 0, 0); idle(1);
        clr(); txn(1, 0, 32'h40, 32'h0, 32'h77777777, 1, 0, 0); idle(1);
        chk("wr_inval_ren", ren_cnt, 2);
        chk("wr_inval_load", bus.dmemload, 32'h77777777);
        for (int i = 0; i < 400; i++) begin
            int k, nw, ra;
            logic [31:0] a;
            bit te;
            k = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: a = 32'h40;
                1: a = 32'h44;
                2: a = 32'h80;
                default: a = $urandom & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 19) == 0) a = a | 32'($urandom_range(1, 3));
            nw = $urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(4, 6);
            te = $urandom_range(0, 19) == 0;
            ra = $urandom_range(0, 29) == 0 ? $urandom_range(1, nw + 1) : 0;
            txn(k != 1, k != 0, a, $urandom, $urandom, nw, te, ra);
            if (exp_derr) begin
                err_idle($urandom_range(1, 4));
                do_reset();
            end
            idle($urandom_range(0, 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
